// File: rtl/cdpga_pll_pkg.sv
// Shared constants for the PLL lock qualifier / reset sequencer.
// State encodings are plain localparams so the debug STATE port matches legacy tooling.
package cdpga_pll_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_WAIT    = 2'd0;
  localparam logic [STATE_W-1:0] S_RELEASE = 2'd1;
  localparam logic [STATE_W-1:0] S_RUN     = 2'd2;

endpackage

// File: rtl/cdpga_ce_div.sv
// One clock-enable channel: strobes once every div cycles (div=0 acts as 1).
// The >= compare lets a shrinking divide take effect on the next edge instead of wrapping.
module cdpga_ce_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last_cnt;
  logic             ce_d;

  always_comb begin
    last_cnt = (div == '0) ? '0 : div - DIV_W'(1);
    cnt_d    = cnt_q + DIV_W'(1);
    ce_d     = 1'b0;
    if (cnt_q >= last_cnt) begin
      cnt_d = '0;
      ce_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
      ce    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce    <= ce_d;
    end
  end

endmodule

// File: rtl/cdpga_pll_seq.sv
// Lock qualifier and staggered reset sequencer for the PLL output domain.
// Any loss of EXT_LOCK after qualification drops everything back to S_WAIT on the same edge.
module cdpga_pll_seq
  import cdpga_pll_pkg::*;
#(
  parameter int LOCK_CYCLES = 8,
  parameter int N_DOMAINS   = 3,
  parameter int STAGGER     = 4,
  parameter int N_CE        = 2,
  parameter int DIV_W       = 8
) (
  input  logic                    REFERENCECLK,
  input  logic                    RESET,
  input  logic                    EXT_LOCK,
  input  logic [N_CE*DIV_W-1:0]   CE_DIV,
  output logic                    LOCK,
  output logic [N_DOMAINS-1:0]    RESET_N,
  output logic [N_CE-1:0]         CLK_EN,
  output logic [STATE_W-1:0]      STATE
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam int SCW = $clog2(STAGGER * N_DOMAINS + 1);

  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [SCW-1:0] STG_MAX   = SCW'(STAGGER * N_DOMAINS);

  logic [STATE_W-1:0]   state_q, state_d;
  logic                 lock_q, lock_d;
  logic [N_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
  logic [SCW-1:0]       stg_cnt_q, stg_cnt_d;
  logic [N_DOMAINS-1:0] rel_hit;
  logic                 ce_clear;

  // Domain gi is released on the edge where stg_cnt_q sits at its last pre-release count.
  for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_rel
    assign rel_hit[gi] = (stg_cnt_q == SCW'(STAGGER * (gi + 1) - 1));
  end

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    rst_n_d    = rst_n_q;
    lock_cnt_d = lock_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    case (state_q)
      S_WAIT: begin
        if (!EXT_LOCK) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d    = S_RELEASE;
          lock_d     = 1'b1;
          lock_cnt_d = '0;
          stg_cnt_d  = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      S_RELEASE, S_RUN: begin
        if (!EXT_LOCK) begin
          state_d    = S_WAIT;
          lock_d     = 1'b0;
          rst_n_d    = '0;
          lock_cnt_d = '0;
          stg_cnt_d  = '0;
        end else if (state_q == S_RELEASE) begin
          rst_n_d = rst_n_q | rel_hit;
          if (stg_cnt_q != STG_MAX) begin
            stg_cnt_d = stg_cnt_q + SCW'(1);
          end
          if (rel_hit[N_DOMAINS-1]) begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d    = S_WAIT;
        lock_d     = 1'b0;
        rst_n_d    = '0;
        lock_cnt_d = '0;
        stg_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      state_q    <= S_WAIT;
      lock_q     <= 1'b0;
      rst_n_q    <= '0;
      lock_cnt_q <= '0;
      stg_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      rst_n_q    <= rst_n_d;
      lock_cnt_q <= lock_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
    end
  end

  // Dividers run only across edges where LOCK is high before and after, so the
  // LOCK-rising edge counts as edge 0 and a lock-loss edge already forces CLK_EN low.
  assign ce_clear = RESET | ~(lock_q & lock_d);

  for (genvar gi = 0; gi < N_CE; gi++) begin : g_ce
    cdpga_ce_div #(
      .DIV_W(DIV_W)
    ) u_ce_div (
      .clk  (REFERENCECLK),
      .clear(ce_clear),
      .div  (CE_DIV[gi*DIV_W +: DIV_W]),
      .ce   (CLK_EN[gi])
    );
  end

  assign LOCK    = lock_q;
  assign RESET_N = rst_n_q;
  assign STATE   = state_q;

endmodule
